riscv_asc_cmd_unit: RTL and testbench
=====================================

# riscv_asc_cmd_unit

Execution-side decoder and command issuer for the application-specific cache (ASC) instructions SET_PRI and RST_BLK (major opcode OPC_ASC, 5'b11101). It sits beside the EX stage, recognises ASC instruction words, stalls the pipeline, and drives a req/ack command handshake toward the data cache's ASC port. It reports completion, illegal encodings, cache errors and timeouts back to the pipeline.

## Interface
- XLEN, 32, register/address width
- ILEN, 32, instruction width
- BLK_BYTES, 32, cache block size in bytes (power of 2)
- PRI_BITS, 3, width of priority field sent to cache
- TIMEOUT, 64, max cycles waiting for asc_ack (≥2)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- ex_instr  in  ILEN  instruction word in EX
- ex_valid  in  1  ex_instr is a live, non-bubble instruction
- ex_flush  in  1  pipeline flush of the EX instruction
- ex_rs1  in  XLEN  rs1 value (target address)
- ex_rs2  in  XLEN  rs2 value (priority, SET_PRI only)
- ex_stall  out  1  hold EX
- ex_done  out  1  1-cycle pulse, ASC instruction retired
- ex_illegal  out  1  1-cycle pulse, OPC_ASC with unsupported funct3
- ex_err  out  1  1-cycle pulse, cache error or timeout
- asc_req  out  1  command request
- asc_cmd  out  2  01=SET_PRI, 10=RST_BLK, 00 when idle
- asc_adr  out  XLEN  block-aligned address
- asc_pri  out  PRI_BITS  priority
- asc_ack  in  1  cache accepted/completed command
- asc_err  in  1  qualifies asc_ack; command failed

## Operation
- Decode: ex_instr[1:0]==2'b11 and ex_instr[6:2]==OPC_ASC. funct3 001 → SET_PRI, 010 → RST_BLK, otherwise illegal. funct7 and rd are ignored.
- FSM states are IDLE, REQ and DONE.
- IDLE: when ex_valid, the instruction is ASC and legal, and ex_flush is low:
  - register asc_cmd and asc_adr = ex_rs1 & ~(BLK_BYTES-1);
  - asc_pri = ex_rs2 saturated to 2^PRI_BITS-1 (RST_BLK: asc_pri=0);
  - load the timeout counter with TIMEOUT-1 and go to REQ.
- IDLE, illegal ASC with ex_valid and no flush: ex_illegal pulses next cycle, no request, stay IDLE.
- REQ: asc_req=1 and command fields stable.
  - asc_ack=1 → DONE. Latch asc_err.
  - Otherwise, counter==0 → IDLE with ex_err pulse, no ex_done.
  - Otherwise the counter decrements.
- DONE: ex_done=1 for one cycle, with ex_err=latched asc_err. Outputs clear, then → IDLE.
- ex_flush while in REQ: the request is not retracted. Mark the command as flushed. On completion go to IDLE with no ex_done/ex_err pulse.
- ex_flush while in DONE: suppress the pulses.
- Reset (any state): next cycle state=IDLE, and all outputs, counter and flags are 0.

## Timing
- All outputs are registered except ex_stall.
- ex_stall = (IDLE & ex_valid & legal ASC & ~ex_flush) | REQ.
- Best case: accept at cycle 0, asc_req at cycle 1, asc_ack at cycle 1, ex_done with ex_stall=0 at cycle 2. That is 2 stall cycles.
- asc_ack outside REQ is ignored.
- The cache holds asc_ack for exactly one cycle per request.
- Timeout: the maximum time asc_req stays high is TIMEOUT cycles. ex_err follows the next cycle.
- A new ASC instruction is accepted earliest in the cycle after DONE. No back-to-back accept in DONE.

## Structure
- OPC_ASC and the SET_PRI/RST_BLK funct3 patterns come from the shared opcodes package.
- Add to the package:
  - a typedef for the 2-bit ASC command enum (ASC_NONE, ASC_SET_PRI, ASC_RST_BLK);
  - the FSM state enum.
- A single module with no sub-modules. The decode is a small function.

## Test plan
- SET_PRI, ex_rs1=0x0000_1234, ex_rs2=5 → asc_cmd=01, asc_adr=0x0000_1220, asc_pri=5. Ack on first REQ cycle → ex_done at cycle 2, ex_stall high for cycles 0–1 only.
- RST_BLK, ex_rs2=0xFFFF_FFFF, ack delayed 10 cycles → asc_pri=0, asc_req held 10 cycles with stable fields, ex_done once.
- SET_PRI with ex_rs2=200 → asc_pri=7 (saturated). Ack with asc_err=1 → ex_done and ex_err in the same cycle.
- funct3=011 with OPC_ASC → ex_illegal pulse, asc_req never asserted, ex_stall 0. Non-ASC opcode → no activity.
- No ack → asc_req high exactly 64 cycles, then ex_err pulse, ex_done stays 0, back to IDLE.
- ex_flush in the 3rd REQ cycle, then ack → no ex_done/ex_err. rstn=0 mid-REQ → asc_req=0 next cycle, and a fresh instruction is then accepted normally.

Source files
------------

// File: rtl/riscv_asc_cmd_unit_pkg.sv
// Shared opcode constants and types for the ASC command unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: OPC_ASC major opcode, SET_PRI/RST_BLK funct3 patterns,
//           ASC command enum, FSM state enum and the instruction decode helper.
package riscv_asc_cmd_unit_pkg;

  localparam logic [4:0] OPC_ASC    = 5'b11101;
  localparam logic [2:0] F3_SET_PRI = 3'b001;
  localparam logic [2:0] F3_RST_BLK = 3'b010;

  typedef enum logic [1:0] {
    ASC_NONE    = 2'b00,
    ASC_SET_PRI = 2'b01,
    ASC_RST_BLK = 2'b10
  } asc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } asc_state_e;

  typedef struct packed {
    logic     is_asc;  // major opcode matches OPC_ASC
    logic     legal;   // funct3 is one of the supported commands
    asc_cmd_e cmd;     // command to issue when legal
  } asc_dec_t;

  // Only the 7-bit opcode and funct3 matter; funct7 and rd are don't-care.
  function automatic asc_dec_t asc_decode(input logic [6:0] opcode,
                                          input logic [2:0] funct3);
    asc_dec_t d;
    d.is_asc = (opcode[1:0] == 2'b11) && (opcode[6:2] == OPC_ASC);
    d.legal  = 1'b0;
    d.cmd    = ASC_NONE;
    if (d.is_asc) begin
      case (funct3)
        F3_SET_PRI: begin
          d.legal = 1'b1;
          d.cmd   = ASC_SET_PRI;
        end
        F3_RST_BLK: begin
          d.legal = 1'b1;
          d.cmd   = ASC_RST_BLK;
        end
        default: begin
          d.legal = 1'b0;
          d.cmd   = ASC_NONE;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/riscv_asc_cmd_unit.sv
// ASC instruction decoder/issuer: stalls EX and drives a req/ack command to the dcache.
// Latency: accept -> asc_req next cycle; ex_done the cycle after asc_ack (min 2 stall cycles).
// Backpressure: asc_req held with stable fields until asc_ack or TIMEOUT cycles elapse.
// Ports: clk/rstn (sync active-low); ex_instr/ex_valid/ex_flush/ex_rs1/ex_rs2 from EX;
//        ex_stall (combinational), ex_done/ex_illegal/ex_err pulses back to the pipeline;
//        asc_req/asc_cmd/asc_adr/asc_pri to the cache, asc_ack/asc_err from the cache.
import riscv_asc_cmd_unit_pkg::*;

module riscv_asc_cmd_unit #(
  parameter int XLEN      = 32,
  parameter int ILEN      = 32,
  parameter int BLK_BYTES = 32,
  parameter int PRI_BITS  = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ILEN-1:0]     ex_instr,
  input  logic                ex_valid,
  input  logic                ex_flush,
  input  logic [XLEN-1:0]     ex_rs1,
  input  logic [XLEN-1:0]     ex_rs2,
  output logic                ex_stall,
  output logic                ex_done,
  output logic                ex_illegal,
  output logic                ex_err,
  output logic                asc_req,
  output logic [1:0]          asc_cmd,
  output logic [XLEN-1:0]     asc_adr,
  output logic [PRI_BITS-1:0] asc_pri,
  input  logic                asc_ack,
  input  logic                asc_err
);

  localparam int                   CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0]      ADR_MASK = ~(XLEN'(BLK_BYTES) - XLEN'(1));
  localparam logic [PRI_BITS-1:0]  PRI_MAX  = '1;

  asc_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flushed_q, flushed_d;
  logic                req_d;
  logic [1:0]          cmd_d;
  logic [XLEN-1:0]     adr_d;
  logic [PRI_BITS-1:0] pri_d;
  logic                done_d, err_d, ill_d;

  asc_dec_t            dec;
  logic                accept;
  logic                flush_seen;
  logic [PRI_BITS-1:0] pri_sat;

  // funct7, rs1/rs2 indices and rd play no part in the decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{ex_instr[ILEN-1:15], ex_instr[11:7]};

  always_comb begin
    dec        = asc_decode(ex_instr[6:0], ex_instr[14:12]);
    accept     = (state_q == ST_IDLE) && ex_valid && dec.legal && !ex_flush;
    ex_stall   = accept || (state_q == ST_REQ);
    pri_sat    = (ex_rs2 > XLEN'(PRI_MAX)) ? PRI_MAX : ex_rs2[PRI_BITS-1:0];
    // A flush seen at any point during REQ (including the ack cycle) kills the report.
    flush_seen = flushed_q || ex_flush;

    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    req_d     = asc_req;
    cmd_d     = asc_cmd;
    adr_d     = asc_adr;
    pri_d     = asc_pri;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ill_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d     = 1'b1;
          cmd_d     = dec.cmd;
          adr_d     = ex_rs1 & ADR_MASK;
          pri_d     = (dec.cmd == ASC_SET_PRI) ? pri_sat : '0;
          cnt_d     = CNT_LOAD;
          flushed_d = 1'b0;
          state_d   = ST_REQ;
        end else if (ex_valid && dec.is_asc && !dec.legal && !ex_flush) begin
          ill_d = 1'b1;
        end
      end

      ST_REQ: begin
        flushed_d = flush_seen;
        if (asc_ack || (cnt_q == '0)) begin
          // Either way the request ends here: drop it and return fields to idle values.
          req_d     = 1'b0;
          cmd_d     = ASC_NONE;
          adr_d     = '0;
          pri_d     = '0;
          flushed_d = 1'b0;
          if (asc_ack) begin
            // ex_err is the registered copy of asc_err, so it lines up with ex_done.
            done_d  = !flush_seen;
            err_d   = !flush_seen && asc_err;
            state_d = flush_seen ? ST_IDLE : ST_DONE;
          end else begin
            err_d   = !flush_seen;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Pulses are visible this cycle; no accept here so the retiring
        // instruction is never picked up a second time.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      asc_req    <= 1'b0;
      asc_cmd    <= ASC_NONE;
      asc_adr    <= '0;
      asc_pri    <= '0;
      ex_done    <= 1'b0;
      ex_err     <= 1'b0;
      ex_illegal <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      asc_req    <= req_d;
      asc_cmd    <= cmd_d;
      asc_adr    <= adr_d;
      asc_pri    <= pri_d;
      ex_done    <= done_d;
      ex_err     <= err_d;
      ex_illegal <= ill_d;
    end
  end

endmodule

// File: tb/tb_riscv_asc_cmd_unit.sv
// Directed bench for riscv_asc_cmd_unit with an expected-event scoreboard.
// Stimulus pushes expected REQ / request-length / response events; a monitor on
// the falling edge observes the DUT and pops/compares each event it sees.
module tb_riscv_asc_cmd_unit;

  localparam int TIMEOUT = 64;
  localparam int EV_REQ  = 0;
  localparam int EV_LEN  = 1;
  localparam int EV_RESP = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // SET_PRI / RST_BLK / funct3=011 under OPC_ASC, and a plain ADD.
  localparam logic [31:0] I_SETPRI   = 32'h0020_9077;
  localparam logic [31:0] I_SETPRI_X = 32'hFE20_92F7;  // funct7 and rd non-zero
  localparam logic [31:0] I_RSTBLK   = 32'h0020_A077;
  localparam logic [31:0] I_ILLEGAL  = 32'h0020_B077;
  localparam logic [31:0] I_ADD      = 32'h0020_8033;

  logic        clk;
  logic        rstn;
  logic [31:0] ex_instr;
  logic        ex_valid;
  logic        ex_flush;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        ex_stall;
  logic        ex_done;
  logic        ex_illegal;
  logic        ex_err;
  logic        asc_req;
  logic [1:0]  asc_cmd;
  logic [31:0] asc_adr;
  logic [2:0]  asc_pri;
  logic        asc_ack;
  logic        asc_err;

  riscv_asc_cmd_unit #(
    .XLEN(32), .ILEN(32), .BLK_BYTES(32), .PRI_BITS(3), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_stall(ex_stall), .ex_done(ex_done), .ex_illegal(ex_illegal), .ex_err(ex_err),
    .asc_req(asc_req), .asc_cmd(asc_cmd), .asc_adr(asc_adr), .asc_pri(asc_pri),
    .asc_ack(asc_ack), .asc_err(asc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [1:0]  cmd;
    logic [31:0] adr;
    logic [2:0]  pri;
    int          len;
    logic        done;
    logic        err;
    logic        ill;
    int          stall;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;

  // ---------------- expectation helpers ----------------
  function automatic ev_t blank_ev(input int kind);
    ev_t e;
    e.kind = kind; e.cmd = 2'b00; e.adr = 32'h0; e.pri = 3'd0; e.len = 0;
    e.done = 1'b0; e.err = 1'b0; e.ill = 1'b0; e.stall = 0;
    return e;
  endfunction

  task automatic push_req(input logic [1:0] cmd, input logic [31:0] adr, input logic [2:0] pri);
    ev_t e = blank_ev(EV_REQ);
    e.cmd = cmd; e.adr = adr; e.pri = pri;
    exp_q.push_back(e);
  endtask

  task automatic push_len(input int len);
    ev_t e = blank_ev(EV_LEN);
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input logic done, input logic err, input logic ill, input int stall);
    ev_t e = blank_ev(EV_RESP);
    e.done = done; e.err = err; e.ill = ill; e.stall = stall;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check_ev(input ev_t got);
    ev_t e;
    bit  ok;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event kind=%0d cmd=%0h adr=%08h pri=%0d len=%0d done=%0b err=%0b ill=%0b stall=%0d, required no event",
               got.kind, got.cmd, got.adr, got.pri, got.len, got.done, got.err, got.ill, got.stall);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == got.kind);
      if (ok) begin
        case (e.kind)
          EV_REQ:  ok = (got.cmd == e.cmd) && (got.adr == e.adr) && (got.pri == e.pri);
          EV_LEN:  ok = (got.len == e.len);
          default: ok = (got.done == e.done) && (got.err == e.err) &&
                        (got.ill == e.ill) && (got.stall == e.stall);
        endcase
      end
      if (!ok) begin
        n_bad++;
        $display("FAIL event t=%0t got kind=%0d cmd=%0h adr=%08h pri=%0d len=%0d done=%0b err=%0b ill=%0b stall=%0d required kind=%0d cmd=%0h adr=%08h pri=%0d len=%0d done=%0b err=%0b ill=%0b stall=%0d",
                 $time, got.kind, got.cmd, got.adr, got.pri, got.len, got.done, got.err, got.ill, got.stall,
                 e.kind, e.cmd, e.adr, e.pri, e.len, e.done, e.err, e.ill, e.stall);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit          mon_prev;
  int          mon_len;
  int          mon_stall;
  logic [1:0]  cap_cmd;
  logic [31:0] cap_adr;
  logic [2:0]  cap_pri;

  initial begin
    ev_t g;
    mon_prev = 1'b0; mon_len = 0; mon_stall = 0;
    cap_cmd = 2'b00; cap_adr = 32'h0; cap_pri = 3'd0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_prev = 1'b0; mon_len = 0; mon_stall = 0;
      end else begin
        if (asc_req && !mon_prev) begin
          g = blank_ev(EV_REQ);
          g.cmd = asc_cmd; g.adr = asc_adr; g.pri = asc_pri;
          cap_cmd = asc_cmd; cap_adr = asc_adr; cap_pri = asc_pri;
          check_ev(g);
          mon_len = 1;
        end else if (asc_req) begin
          mon_len++;
          n_cmp++;
          if (asc_cmd !== cap_cmd || asc_adr !== cap_adr || asc_pri !== cap_pri) begin
            n_bad++;
            $display("FAIL req_stable t=%0t got cmd=%0h adr=%08h pri=%0d required cmd=%0h adr=%08h pri=%0d",
                     $time, asc_cmd, asc_adr, asc_pri, cap_cmd, cap_adr, cap_pri);
          end
        end
        if (!asc_req && mon_prev) begin
          g = blank_ev(EV_LEN);
          g.len = mon_len;
          check_ev(g);
        end
        if (ex_done || ex_err || ex_illegal) begin
          g = blank_ev(EV_RESP);
          g.done = ex_done; g.err = ex_err; g.ill = ex_illegal; g.stall = mon_stall;
          check_ev(g);
          mon_stall = 0;
        end else if (ex_stall) begin
          mon_stall++;
        end else begin
          mon_stall = 0;
        end
        mon_prev = asc_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one instruction for a cycle, then act as the cache: ack in REQ
  // cycle ack_at (0 = never), flush in REQ cycle flush_at, reset in REQ cycle rst_at.
  task automatic run_cmd(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int ack_at, input logic aerr, input int flush_at, input int rst_at);
    @(posedge clk); #1;
    ex_instr = instr; ex_rs1 = rs1; ex_rs2 = rs2; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_instr = NOP;
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      ex_flush = (c == flush_at);
      asc_ack  = (c == ack_at);
      asc_err  = (c == ack_at) && aerr;
      rstn     = !(c == rst_at);
      @(posedge clk); #1;
      ex_flush = 1'b0; asc_ack = 1'b0; asc_err = 1'b0; rstn = 1'b1;
      if (rst_at > 0 && c >= rst_at) begin
        chk("rst_asc_req", {31'b0, asc_req}, 32'h0);
        chk("rst_asc_cmd", {30'b0, asc_cmd}, 32'h0);
        chk("rst_asc_adr", asc_adr, 32'h0);
        chk("rst_ex_stall", {31'b0, ex_stall}, 32'h0);
        break;
      end
      if (ack_at > 0 && c >= ack_at) break;
    end
    idle(3);
  endtask

  task automatic issue_only(input logic [31:0] instr, input logic valid, input logic flush);
    @(posedge clk); #1;
    ex_instr = instr; ex_rs1 = 32'h0000_0100; ex_rs2 = 32'd3; ex_valid = valid; ex_flush = flush;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_flush = 1'b0; ex_instr = NOP;
    idle(3);
  endtask

  initial begin
    rstn = 1'b0; ex_instr = NOP; ex_valid = 1'b0; ex_flush = 1'b0;
    ex_rs1 = 32'h0; ex_rs2 = 32'h0; asc_ack = 1'b0; asc_err = 1'b0;
    idle(3);
    chk("reset_asc_req",    {31'b0, asc_req},    32'h0);
    chk("reset_asc_cmd",    {30'b0, asc_cmd},    32'h0);
    chk("reset_asc_adr",    asc_adr,             32'h0);
    chk("reset_asc_pri",    {29'b0, asc_pri},    32'h0);
    chk("reset_ex_done",    {31'b0, ex_done},    32'h0);
    chk("reset_ex_err",     {31'b0, ex_err},     32'h0);
    chk("reset_ex_illegal", {31'b0, ex_illegal}, 32'h0);
    chk("reset_ex_stall",   {31'b0, ex_stall},   32'h0);
    rstn = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Best case: ack on the first REQ cycle, two stall cycles.
    push_req(2'b01, 32'h0000_1220, 3'd5); push_len(1); push_resp(1'b1, 1'b0, 1'b0, 2);
    run_cmd(I_SETPRI, 32'h0000_1234, 32'd5, 1, 1'b0, 0, 0);

    // RST_BLK forces priority 0; ack after 10 REQ cycles.
    push_req(2'b10, 32'h8000_ABC0, 3'd0); push_len(10); push_resp(1'b1, 1'b0, 1'b0, 11);
    run_cmd(I_RSTBLK, 32'h8000_ABCD, 32'hFFFF_FFFF, 10, 1'b0, 0, 0);

    // Saturated priority, error ack reported alongside ex_done; funct7/rd ignored.
    push_req(2'b01, 32'hDEAD_BEE0, 3'd7); push_len(2); push_resp(1'b1, 1'b1, 1'b0, 3);
    run_cmd(I_SETPRI_X, 32'hDEAD_BEEF, 32'd200, 2, 1'b1, 0, 0);

    // Illegal funct3: pulse only, no request, no stall.
    push_resp(1'b0, 1'b0, 1'b1, 0);
    issue_only(I_ILLEGAL, 1'b1, 1'b0);

    // No activity: non-ASC opcode, bubble, flushed accept, stray ack in IDLE.
    issue_only(I_ADD, 1'b1, 1'b0);
    issue_only(I_SETPRI, 1'b0, 1'b0);
    issue_only(I_RSTBLK, 1'b1, 1'b1);
    asc_ack = 1'b1; asc_err = 1'b1;
    idle(1);
    asc_ack = 1'b0; asc_err = 1'b0;
    idle(3);

    // Timeout: request held exactly TIMEOUT cycles, then ex_err alone.
    push_req(2'b01, 32'h0000_0040, 3'd7); push_len(TIMEOUT); push_resp(1'b0, 1'b1, 1'b0, TIMEOUT + 1);
    run_cmd(I_SETPRI, 32'h0000_0040, 32'd7, 0, 1'b0, 0, 0);

    // Flush in REQ cycle 3, error ack in cycle 5: request completes, nothing reported.
    push_req(2'b10, 32'h0000_0100, 3'd0); push_len(5);
    run_cmd(I_RSTBLK, 32'h0000_011F, 32'd8, 5, 1'b1, 3, 0);

    // Reset during REQ cycle 3, then a fresh command runs normally.
    push_req(2'b01, 32'h0000_0060, 3'd1); push_len(3);
    run_cmd(I_SETPRI, 32'h0000_007F, 32'd1, 0, 1'b0, 0, 3);
    push_req(2'b01, 32'h0000_0020, 3'd3); push_len(1); push_resp(1'b1, 1'b0, 1'b0, 2);
    run_cmd(I_SETPRI, 32'h0000_0020, 32'd3, 1, 1'b0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
